acc_strobe_sequencer: RTL and testbench
=======================================

Name: acc_strobe_sequencer

Overview:
- Controller for the latch-based 65c02 accumulator.
- Arbitrates three requesters: the instruction-decode load from the data bus, the ALU writeback, and the increment/decrement unit.
- Converts each granted request into a single-cycle, mutually exclusive strobe on instruction_decode_in, alu_to_accumulator_xfer, a_increment or a_decrement.
- Inserts settle gaps after each strobe so the transparent latch never sees overlapping or back-to-back enables. Sits between the decoder/ALU control and the accumulator.

Parameters:
- SETTLE_CYCLES, 1, strobe-low cycles after every pulse before the next pulse (legal 1..15).
- CNT_W, 3, width of the inc/dec repeat-count field.

Ports:
- fclk  input  1  clock, rising edge.
- resb  input  1  asynchronous active-low reset.
- ld_valid  input  1  decode requests accumulator load from data bus.
- ld_ready  output  1  load request accepted this cycle.
- alu_valid  input  1  ALU requests result transfer into accumulator.
- alu_ready  output  1  ALU request accepted this cycle.
- id_valid  input  1  inc/dec unit request.
- id_ready  output  1  inc/dec request accepted this cycle.
- id_dir  input  1  0 = increment, 1 = decrement; sampled on acceptance.
- id_count  input  CNT_W  number of steps; 0 is treated as 1; sampled on acceptance.
- flush  input  1  synchronous cancel of remaining inc/dec steps.
- instruction_decode_in  output  1  accumulator load strobe.
- alu_to_accumulator_xfer  output  1  ALU transfer strobe.
- a_increment  output  1  increment strobe.
- a_decrement  output  1  decrement strobe.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, fclk. resb is asynchronous and active-low.
- While resb = 0:
  - all strobes, readies and busy are 0;
  - state = IDLE, step counter = 0, RR pointer = ld.
  - Reset asserted mid-pulse drops the strobe immediately (asynchronously).
- Strobe outputs:
  - All four strobes are registered.
  - At most one strobe is high in any cycle.
  - Each strobe is high for exactly one cycle.
- States:
  - IDLE: readies are combinational; exactly one ready is high, for the granted valid requester, and only in IDLE. A grant with valid is an acceptance at the rising edge; the next state is PULSE. With no valid, remain in IDLE.
  - PULSE: the selected strobe is high for this one cycle. Next state is GAP.
  - GAP: all strobes low. A counter runs SETTLE_CYCLES cycles. On expiry:
    - if inc/dec steps remain (remaining step counter > 0), go to PULSE;
    - otherwise go to IDLE.
- Inc/dec step counter:
  - On acceptance, remaining = max(id_count, 1) - 1.
  - It is decremented on each re-entry to PULSE.
  - id_dir is latched and held for all steps.
- Latency:
  - Acceptance at edge N gives the strobe in cycle N+1.
  - The next acceptance is possible no earlier than edge N+2+SETTLE_CYCLES.
  - Throughput is one op per 2+SETTLE_CYCLES cycles.
- Grant priority (default): ld > alu > id, evaluated only in IDLE.
- flush:
  - In PULSE or GAP, flush forces remaining = 0. The current pulse completes and the GAP still runs in full, so latch timing is preserved.
  - In IDLE, flush has no effect.
  - If flush and an acceptance occur in the same cycle, the acceptance wins. The new request is not flushed.
- Requester valids may drop while not ready. Nothing is queued internally.
- The block never issues a strobe without a prior acceptance.

Optional Feature:
- Macro: ACC_STROBE_SEQ_RR_EN.
- When defined:
  - Grant uses round-robin over the order ld, alu, id.
  - Priority starts at the requester after the last accepted one.
  - The pointer updates only on acceptance and resets to ld.
- When not defined: fixed priority ld > alu > id, and no pointer register exists.

Decomposition:
- Package acc_seq_pkg holds:
  - a state enum (IDLE, PULSE, GAP);
  - a requester enum (REQ_LD, REQ_ALU, REQ_ID);
  - an op enum for the latched strobe select;
  - a SETTLE_CYCLES_DEFAULT constant.
- One sub-module, acc_seq_arbiter: combinational grant from the three valids plus the optional RR pointer. It also owns the RR pointer register when ACC_STROBE_SEQ_RR_EN is defined.

Test Plan:
- Single load, SETTLE_CYCLES=1: ld_valid held from cycle 0 → ld_ready=1 in cycle 0; instruction_decode_in=1 only in cycle 1; busy in cycles 1–2; IDLE in cycle 3.
- Simultaneous ld_valid, alu_valid and id_valid at cycle 0, fixed priority → grants in the order ld (strobe cycle 1), alu (cycle 4), id (cycle 7).
- Same stimulus with ACC_STROBE_SEQ_RR_EN → second round after the ld grant starts at alu. Verify rotation over six requests: ld, alu, id, ld, alu, id.
- id_dir=1, id_count=3, SETTLE_CYCLES=2 → a_decrement pulses in cycles 1, 4 and 7; IDLE at cycle 10. id_count=0 → exactly one pulse.
- flush asserted in cycle 2 during id_count=5 increment → only one a_increment pulse (cycle 1); IDLE at cycle 3.
- resb low during a PULSE cycle → strobe drops without waiting for a clock edge. After release: all outputs 0, state IDLE, a pending valid is accepted on the first edge.
- In all scenarios, assert at most one strobe high per cycle.

Source files
------------

// File: rtl/acc_seq_pkg.sv
// Shared types and helpers for the accumulator strobe sequencer.
// Optional round-robin grant is selected with ACC_STROBE_SEQ_RR_EN.
package acc_seq_pkg;

   localparam int SETTLE_CYCLES_DEFAULT = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      REQ_LD  = 2'd0,
      REQ_ALU = 2'd1,
      REQ_ID  = 2'd2
   } req_e;

   typedef enum logic [1:0] {
      OP_LD  = 2'd0,
      OP_ALU = 2'd1,
      OP_INC = 2'd2,
      OP_DEC = 2'd3
   } op_e;

   // One-hot pick, bit 0 has highest priority.
   function automatic logic [2:0] prio3(input logic [2:0] v);
      if (v[0])      return 3'b001;
      else if (v[1]) return 3'b010;
      else if (v[2]) return 3'b100;
      else           return 3'b000;
   endfunction

   // Strobe vector {dec, inc, alu, ld} for a latched op.
   function automatic logic [3:0] op_strobe(input op_e op);
      case (op)
         OP_LD:   return 4'b0001;
         OP_ALU:  return 4'b0010;
         OP_INC:  return 4'b0100;
         default: return 4'b1000;
      endcase
   endfunction

endpackage

// File: rtl/acc_seq_arbiter.sv
// Grant logic for ld / alu / id requesters.
// ACC_STROBE_SEQ_RR_EN: round-robin with a pointer owned here; otherwise
// fixed priority ld > alu > id with no state at all.
module acc_seq_arbiter
   import acc_seq_pkg::*;
(
`ifdef ACC_STROBE_SEQ_RR_EN
   input  logic       fclk,
   input  logic       resb,
   input  logic       accept,
`endif
   input  logic [2:0] valid,
   output logic [2:0] gnt
);

`ifdef ACC_STROBE_SEQ_RR_EN
   req_e       ptr_q, ptr_d;
   logic [2:0] v_rot, g_rot;

   // Rotate valids so the pointer position sits at bit 0, pick, rotate back.
   always_comb begin
      v_rot = valid;
      gnt   = 3'b000;
      case (ptr_q)
         REQ_ALU: v_rot = {valid[0], valid[2], valid[1]};
         REQ_ID:  v_rot = {valid[1], valid[0], valid[2]};
         default: v_rot = valid;
      endcase
      g_rot = prio3(v_rot);
      case (ptr_q)
         REQ_ALU: gnt = {g_rot[1], g_rot[0], g_rot[2]};
         REQ_ID:  gnt = {g_rot[0], g_rot[2], g_rot[1]};
         default: gnt = g_rot;
      endcase
   end

   // Pointer moves to the requester after the one just accepted.
   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         if (gnt[0])      ptr_d = REQ_ALU;
         else if (gnt[1]) ptr_d = REQ_ID;
         else if (gnt[2]) ptr_d = REQ_LD;
      end
   end

   // Pointer register, restarts at ld.
   always_ff @(posedge fclk or negedge resb) begin
      if (!resb) ptr_q <= REQ_LD;
      else       ptr_q <= ptr_d;
   end
`else
   // Fixed priority ld > alu > id.
   always_comb gnt = prio3(valid);
`endif

endmodule

// File: rtl/acc_strobe_sequencer.sv
// Strobe sequencer for the latch-based 65c02 accumulator: accepts one request
// at a time, issues a single-cycle registered strobe, then holds all strobes
// low for SETTLE_CYCLES so the transparent latch never sees adjacent enables.
// Inc/dec requests repeat the pulse id_count times (0 counts as 1).
// ACC_STROBE_SEQ_RR_EN selects round-robin arbitration in acc_seq_arbiter.
module acc_strobe_sequencer
   import acc_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
   parameter int CNT_W         = 3
) (
   input  logic             fclk,
   input  logic             resb,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic             id_dir,
   input  logic [CNT_W-1:0] id_count,
   input  logic             flush,
   output logic             instruction_decode_in,
   output logic             alu_to_accumulator_xfer,
   output logic             a_increment,
   output logic             a_decrement,
   output logic             busy
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_e           state_q, state_d;
   logic [3:0]       gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0] remain_q, remain_d, remain_eff;
   op_e              op_q, op_d;
   logic [3:0]       strb_q, strb_d;
   logic [2:0]       valid, gnt, rdy;
   logic             idle, accept;

   assign valid      = {id_valid, alu_valid, ld_valid};
   // Readies are only offered in IDLE and are forced low while in reset.
   assign idle       = resb && (state_q == IDLE);
   assign rdy        = idle ? gnt : 3'b000;
   assign accept     = |rdy;
   assign remain_eff = flush ? '0 : remain_q;

   assign ld_ready  = rdy[0];
   assign alu_ready = rdy[1];
   assign id_ready  = rdy[2];
   assign busy      = (state_q != IDLE);

   assign instruction_decode_in   = strb_q[0];
   assign alu_to_accumulator_xfer = strb_q[1];
   assign a_increment             = strb_q[2];
   assign a_decrement             = strb_q[3];

   acc_seq_arbiter u_arb (
`ifdef ACC_STROBE_SEQ_RR_EN
      .fclk   (fclk),
      .resb   (resb),
      .accept (accept),
`endif
      .valid  (valid),
      .gnt    (gnt)
   );

   // Sequencer next state: strobe is computed one cycle early so it is a flop.
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      remain_d  = remain_q;
      op_d      = op_q;
      strb_d    = 4'b0000;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (gnt[0]) begin
                  op_d     = OP_LD;
                  remain_d = '0;
               end else if (gnt[1]) begin
                  op_d     = OP_ALU;
                  remain_d = '0;
               end else if (gnt[2]) begin
                  op_d     = id_dir ? OP_DEC : OP_INC;
                  remain_d = (id_count == '0) ? '0 : id_count - CNT_ONE;
               end
               strb_d  = op_strobe(op_d);
               state_d = PULSE;
            end
         end
         PULSE: begin
            state_d   = GAP;
            gap_cnt_d = SETTLE_LAST;
            remain_d  = remain_eff;
         end
         GAP: begin
            // flush in the final gap cycle must still cancel the next step
            remain_d = remain_eff;
            if (gap_cnt_q == 4'd0) begin
               if (remain_eff != '0) begin
                  state_d  = PULSE;
                  remain_d = remain_eff - CNT_ONE;
                  strb_d   = op_strobe(op_q);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered strobes; reset drops a strobe immediately.
   always_ff @(posedge fclk or negedge resb) begin
      if (!resb) begin
         state_q   <= IDLE;
         gap_cnt_q <= 4'd0;
         remain_q  <= '0;
         op_q      <= OP_LD;
         strb_q    <= 4'b0000;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
         remain_q  <= remain_d;
         op_q      <= op_d;
         strb_q    <= strb_d;
      end
   end

endmodule

// File: tb/tb_acc_strobe_sequencer.sv
// Scoreboard bench for acc_strobe_sequencer. The reference model works at
// transaction level: each accepted op is turned into a list of pulse cycles
// (start + k*(SETTLE+1)) and a "free from" cycle; a monitor pops and checks.
module tb_acc_strobe_sequencer;

   localparam int S  = 2;
   localparam int CW = 3;

   logic          fclk = 1'b0;
   logic          resb = 1'b0;
   logic          ld_valid, alu_valid, id_valid, id_dir, flush;
   logic [CW-1:0] id_count;
   logic          ld_ready, alu_ready, id_ready;
   logic          instruction_decode_in, alu_to_accumulator_xfer, a_increment, a_decrement, busy;

   logic          lv = 0, av = 0, iv = 0, dir = 0, fl = 0;
   logic [CW-1:0] cnt = '0;

   assign ld_valid  = lv;
   assign alu_valid = av;
   assign id_valid  = iv;
   assign id_dir    = dir;
   assign id_count  = cnt;
   assign flush     = fl;

   always #5 fclk = ~fclk;

   acc_strobe_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
      .fclk(fclk), .resb(resb),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_dir(id_dir), .id_count(id_count), .flush(flush),
      .instruction_decode_in(instruction_decode_in),
      .alu_to_accumulator_xfer(alu_to_accumulator_xfer),
      .a_increment(a_increment), .a_decrement(a_decrement),
      .busy(busy)
   );

   typedef struct { int cyc; logic [3:0] sel; } exp_t;
   exp_t q[$];

   int cyc = 0;
   int n_chk = 0, n_fail = 0;
   int next_free = 0, op_start = 0, rr_ptr = 0, last_g = -1;

   always @(posedge fclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [3:0] strobes();
      return {a_decrement, a_increment, alu_to_accumulator_xfer, instruction_decode_in};
   endfunction

   // One cycle: check busy/ready against the model, apply flush, schedule grant.
   task automatic step();
      logic [2:0] v, exp_rdy;
      logic [3:0] sel;
      int c, g, r, steps, k;
      @(negedge fclk);
      c = cyc;
      chk("busy", busy, c < next_free);
      v = {iv, av, lv};
      if (fl && c < next_free) begin
         k = (c - op_start) / (S + 1);
         next_free = op_start + k * (S + 1) + 1 + S;
         while (q.size() > 0 && q[$].cyc > c) void'(q.pop_back());
      end
      exp_rdy = 3'b000;
      g = -1;
      if (c >= next_free)
         for (int i = 0; i < 3; i++) begin
            r = (rr_ptr + i) % 3;
            if (g < 0 && v[r]) g = r;
         end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("ready", {id_ready, alu_ready, ld_ready}, exp_rdy);
      last_g = g;
      if (g >= 0) begin
         sel   = (g == 0) ? 4'b0001 : (g == 1) ? 4'b0010 : (dir ? 4'b1000 : 4'b0100);
         steps = (g == 2) ? ((cnt == 0) ? 1 : int'(cnt)) : 1;
         op_start = c + 1;
         for (int j = 0; j < steps; j++) q.push_back('{cyc: c + 1 + j * (S + 1), sel: sel});
         next_free = c + 1 + steps * (S + 1);
`ifdef ACC_STROBE_SEQ_RR_EN
         rr_ptr = (g + 1) % 3;
`endif
      end
      @(posedge fclk);
      #1;
   endtask

   // Requesters drop their valid once the model says they were accepted.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         case (last_g)
            0: lv = 0;
            1: av = 0;
            2: iv = 0;
            default: ;
         endcase
      end
   endtask

   // Monitor: every strobe must match the scoreboard head; at most one high.
   always @(negedge fclk) begin
      logic [3:0] s;
      exp_t e;
      if (resb) begin
         s = strobes();
         chk("one_hot", $countones(s) <= 1, 1);
         if (s != 4'b0000) begin
            if (q.size() == 0) chk("spurious_strobe", s, 0);
            else begin
               e = q.pop_front();
               chk("strobe_cycle", cyc, e.cyc);
               chk("strobe_sel", s, e.sel);
            end
         end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            chk("missing_strobe", s, q[0].sel);
            void'(q.pop_front());
         end
      end
   end

   initial begin
      // reset state, with every requester asking
      lv = 1; av = 1; iv = 1;
      repeat (2) @(posedge fclk);
      #1;
      chk("rst_strobes", strobes(), 0);
      chk("rst_ready", {id_ready, alu_ready, ld_ready}, 0);
      chk("rst_busy", busy, 0);
      lv = 0; av = 0; iv = 0;
      resb = 1;

      // single load
      lv = 1;
      run(S + 4);

      // all three at once, each drops after its grant
      lv = 1; av = 1; iv = 1; dir = 0; cnt = 1;
      run(3 * (S + 2) + 2);

      // persistent requesters over six grants (rotation when RR is built in)
      for (int i = 0; i < 6 * (S + 2); i++) begin
         lv = 1; av = 1; iv = 1;
         step();
      end
      lv = 0; av = 0; iv = 0;
      run(S + 3);

      // decrement x3, then count 0 gives one pulse
      iv = 1; dir = 1; cnt = 3;
      run(3 * (S + 1) + 3);
      iv = 1; dir = 0; cnt = 0;
      run(S + 4);

      // flush in the first gap of a 5-step increment
      iv = 1; dir = 0; cnt = 5;
      step();
      iv = 0;
      step();
      fl = 1;
      step();
      fl = 0;
      run(2 * (S + 1) + 2);

      // flush together with acceptance: acceptance wins
      iv = 1; cnt = 2; fl = 1;
      step();
      iv = 0; fl = 0;
      run(2 * (S + 1) + 3);

      // reset in the middle of a pulse
      lv = 1;
      step();
      lv = 0;
      @(negedge fclk);
      #1;
      resb = 0;
      #1;
      chk("async_drop", strobes(), 0);
      q.delete();
      next_free = 0; op_start = 0; rr_ptr = 0;
      lv = 1;
      @(posedge fclk);
      #1;
      chk("rst2_strobes", strobes(), 0);
      chk("rst2_ready", {id_ready, alu_ready, ld_ready}, 0);
      chk("rst2_busy", busy, 0);
      resb = 1;
      run(S + 4);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (!lv && $urandom_range(3) == 0) lv = 1;
         if (!av && $urandom_range(3) == 0) av = 1;
         if (!iv && $urandom_range(3) == 0) iv = 1;
         if ($urandom_range(15) == 0) lv = 0;
         if ($urandom_range(15) == 0) av = 0;
         dir = 1'($urandom);
         cnt = CW'($urandom);
         fl  = ($urandom_range(7) == 0);
         run(1);
      end

      lv = 0; av = 0; iv = 0; fl = 0;
      run(8 * (S + 1) + 4);
      chk("drain", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
